// File: rtl/wb_pkg.sv
// wb_pkg: shared load encodings, FSM states and counter width for the writeback stage
package wb_pkg;
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam int CNT_W = 8;
    typedef enum logic {IDLE, WAIT_LOAD} state_t;
endpackage

// File: rtl/load_align.sv
// load_align: extracts and extends the addressed byte/halfword of a load word
// Ports: i_data raw word, i_funct3 size/sign, i_addr_lo byte offset, o_data aligned word
module load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [2:0]        i_funct3,
    input  logic [1:0]        i_addr_lo,
    output logic [DATA_W-1:0] o_data
);
    logic [DATA_W-1:0] w_sh;
    logic [7:0]        w_b;
    logic [15:0]       w_h;
    assign w_sh = i_data >> {i_addr_lo, 3'b000};
    assign w_b  = w_sh[7:0];
    // halfword select ignores addr_lo[0]
    assign w_h  = i_addr_lo[1] ? i_data[31:16] : i_data[15:0];
    always_comb
        o_data = i_funct3 == LB  ? {{(DATA_W-8){w_b[7]}}, w_b} :
                 i_funct3 == LBU ? {{(DATA_W-8){1'b0}}, w_b} :
                 i_funct3 == LH  ? {{(DATA_W-16){w_h[15]}}, w_h} :
                 i_funct3 == LHU ? {{(DATA_W-16){1'b0}}, w_h} :
                 i_data;
endmodule

// File: rtl/stage5_writeback.sv
// stage5_writeback: register-file writeback of ALU results and one outstanding load
// Ports: ex_* stage-4 result handshake, mem_* load response, rs1/rs2 -> hazard_stall,
// write_* register-file port, load_busy, err (sticky timeout / spurious response)
module stage5_writeback
    import wb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [4:0]        ex_rd,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_is_load,
    input  logic [2:0]        ex_funct3,
    input  logic [1:0]        ex_addr_lo,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    output logic              hazard_stall,
    output logic [DATA_W-1:0] write_data,
    output logic [4:0]        write_select,
    output logic              write_en,
    output logic              load_busy,
    output logic              err
);
    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [4:0]         r_rd;
    logic [2:0]         r_f3;
    logic [1:0]         r_lo;
    logic [DATA_W-1:0]  w_aligned;
    logic               w_wait, w_alu, w_ld_acc, w_resp, w_tmo;

    load_align #(.DATA_W(DATA_W)) u_align (
        .i_data   (mem_rdata),
        .i_funct3 (r_f3),
        .i_addr_lo(r_lo),
        .o_data   (w_aligned)
    );

    assign w_wait    = r_state == WAIT_LOAD;
    assign load_busy = w_wait;
    assign hazard_stall = w_wait && r_rd != 5'd0 && (rs1 == r_rd || rs2 == r_rd);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;

    // while waiting: the load owns the write port, only one load may be pending,
    // and a younger write to the same rd must not overtake it
    always_comb begin
        ex_ready = !w_wait || !(mem_rvalid || ex_is_load || (ex_rd == r_rd && ex_rd != 5'd0));
        w_alu    = ex_valid && ex_ready && !ex_is_load;
        w_ld_acc = ex_valid && !w_wait && ex_is_load;
        w_resp   = w_wait && mem_rvalid;
        w_tmo    = w_wait && !mem_rvalid && r_cnt == CNT_W'(TIMEOUT - 1);
        w_next   = r_state;
        if (!w_wait && w_ld_acc)      w_next = WAIT_LOAD;
        if (w_wait && (w_resp || w_tmo)) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            write_en     <= 1'b0;
            write_select <= 5'd0;
            write_data   <= '0;
            err          <= 1'b0;
            r_cnt        <= '0;
            r_rd         <= 5'd0;
            r_f3         <= 3'd0;
            r_lo         <= 2'd0;
        end else begin
            write_en <= 1'b0;
            if (w_resp) begin
                write_en     <= r_rd != 5'd0;
                write_select <= r_rd;
                write_data   <= w_aligned;
            end else if (w_alu) begin
                write_en     <= ex_rd != 5'd0;
                write_select <= ex_rd;
                write_data   <= ex_result;
            end
            if (w_ld_acc) begin
                r_rd  <= ex_rd;
                r_f3  <= ex_funct3;
                r_lo  <= ex_addr_lo;
                r_cnt <= '0;
            end else if (w_wait) r_cnt <= r_cnt + 1'b1;
            if (w_tmo || (!w_wait && mem_rvalid)) err <= 1'b1;
        end
endmodule

// File: tb/tb_stage5_writeback.sv
// tb_stage5_writeback: directed self-checking bench for stage5_writeback
module tb_stage5_writeback;
    logic        clk = 0, reset_n = 0;
    logic        ex_valid = 0, ex_ready, ex_is_load = 0, mem_rvalid = 0;
    logic [4:0]  ex_rd = 0, rs1 = 0, rs2 = 0, write_select;
    logic [31:0] ex_result = 0, mem_rdata = 0, write_data;
    logic [2:0]  ex_funct3 = 0;
    logic [1:0]  ex_addr_lo = 0;
    logic        hazard_stall, write_en, load_busy, err;
    int checks = 0, errors = 0;

    stage5_writeback #(.DATA_W(32), .TIMEOUT(64)) dut (
        .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rd(ex_rd), .ex_result(ex_result), .ex_is_load(ex_is_load),
        .ex_funct3(ex_funct3), .ex_addr_lo(ex_addr_lo), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .rs1(rs1), .rs2(rs2), .hazard_stall(hazard_stall),
        .write_data(write_data), .write_select(write_select), .write_en(write_en),
        .load_busy(load_busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
        ex_valid = 1; ex_is_load = 1; ex_rd = rd; ex_funct3 = f3; ex_addr_lo = lo;
        step();
        ex_valid = 0; ex_is_load = 0; ex_rd = 0;
    endtask

    task automatic respond(input logic [31:0] d);
        mem_rvalid = 1; mem_rdata = d;
        step();
        mem_rvalid = 0;
    endtask

    initial begin
        #12;
        chk("rst_wen", write_en, 0);
        chk("rst_sel", write_select, 0);
        chk("rst_data", write_data, 0);
        chk("rst_busy", load_busy, 0);
        chk("rst_err", err, 0);
        step();
        reset_n = 1;
        step();

        ex_valid = 1; ex_rd = 5; ex_result = 32'h1234_5678;
        #1 chk("alu_ready", ex_ready, 1);
        step();
        chk("alu_wen", write_en, 1);
        chk("alu_sel", write_select, 5);
        chk("alu_data", write_data, 32'h1234_5678);
        ex_rd = 0; ex_result = 32'hDEAD_BEEF;
        step();
        chk("x0_wen", write_en, 0);
        ex_valid = 0;
        step();
        chk("idle_wen", write_en, 0);

        issue_load(7, 3'b000, 2);
        chk("lb_busy", load_busy, 1);
        chk("lb_nowr", write_en, 0);
        rs1 = 7;
        #1 chk("haz_rs1", hazard_stall, 1);
        rs1 = 0; rs2 = 7;
        #1 chk("haz_rs2", hazard_stall, 1);
        rs2 = 3;
        #1 chk("haz_none", hazard_stall, 0);
        rs2 = 0;
        step(); step();
        respond(32'h0080_0000);
        chk("lb_wen", write_en, 1);
        chk("lb_sel", write_select, 7);
        chk("lb_data", write_data, 32'hFFFF_FF80);
        chk("lb_busy_drop", load_busy, 0);
        rs1 = 7;
        #1 chk("haz_idle", hazard_stall, 0);
        rs1 = 0;

        issue_load(9, 3'b101, 3);
        respond(32'hBEEF_1234);
        chk("lhu_data", write_data, 32'h0000_BEEF);
        chk("lhu_sel", write_select, 9);
        issue_load(10, 3'b010, 1);
        respond(32'hCAFE_F00D);
        chk("lw_data", write_data, 32'hCAFE_F00D);
        issue_load(11, 3'b001, 1);
        respond(32'h0000_8001);
        chk("lh_data", write_data, 32'hFFFF_8001);
        issue_load(12, 3'b100, 3);
        respond(32'hA5FF_FFFF);
        chk("lbu_data", write_data, 32'h0000_00A5);
        issue_load(0, 3'b010, 0);
        respond(32'h5555_5555);
        chk("ld_x0_wen", write_en, 0);

        issue_load(3, 3'b010, 0);
        ex_valid = 1; ex_rd = 8; ex_result = 32'h88;
        #1 chk("wait_alu_ready", ex_ready, 1);
        step();
        chk("wait_alu_sel", write_select, 8);
        chk("wait_alu_wen", write_en, 1);
        ex_rd = 3; ex_result = 32'h33;
        #1 chk("waw_block", ex_ready, 0);
        step();
        chk("waw_nowr", write_en, 0);
        ex_is_load = 1; ex_rd = 13;
        #1 chk("ld2_block", ex_ready, 0);
        ex_is_load = 0; ex_rd = 3;
        mem_rvalid = 1; mem_rdata = 32'h1111_1111;
        #1 chk("resp_block", ex_ready, 0);
        step();
        mem_rvalid = 0;
        chk("waw_ld_sel", write_select, 3);
        chk("waw_ld_data", write_data, 32'h1111_1111);
        #1 chk("waw_ready", ex_ready, 1);
        step();
        chk("waw_alu_data", write_data, 32'h33);
        chk("waw_alu_wen", write_en, 1);
        ex_valid = 0;

        issue_load(6, 3'b010, 0);
        ex_valid = 1; ex_rd = 4; ex_result = 32'h44; mem_rvalid = 1; mem_rdata = 32'h66;
        #1 chk("same_block", ex_ready, 0);
        step();
        mem_rvalid = 0;
        chk("same_ld_sel", write_select, 6);
        chk("same_ld_data", write_data, 32'h66);
        step();
        chk("same_alu_sel", write_select, 4);
        chk("same_alu_data", write_data, 32'h44);
        ex_valid = 0;
        step();

        issue_load(14, 3'b010, 0);
        repeat (63) step();
        chk("tmo_busy_before", load_busy, 1);
        chk("tmo_err_before", err, 0);
        step();
        chk("tmo_busy", load_busy, 0);
        chk("tmo_err", err, 1);
        chk("tmo_nowr", write_en, 0);
        respond(32'h7777_7777);
        chk("stray_err", err, 1);
        chk("stray_nowr", write_en, 0);

        ex_valid = 1; ex_rd = 21; ex_result = 32'h2121;
        step();
        issue_load(22, 3'b010, 0);
        chk("pre_rst_sel", write_select, 21);
        #2 reset_n = 0;
        #1;
        chk("arst_sel", write_select, 0);
        chk("arst_data", write_data, 0);
        chk("arst_busy", load_busy, 0);
        chk("arst_err", err, 0);
        step();
        reset_n = 1;
        respond(32'h9999_9999);
        chk("post_rst_err", err, 1);
        chk("post_rst_nowr", write_en, 0);
        chk("post_rst_busy", load_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
